fb_write_arbiter: RTL

//  Round-robin arbiter sharing the single framebuffer pixel-write port between the drawing engines
//  (soft-reset/clear, line draw, rect fill, test pattern, ...). Each engine's rts/rtr pair comes from the command processor.
//  A grant is held for a whole primitive (until a beat with req_last), so pixels of one primitive stay contiguous.
//  A grant-cycle watchdog guarantees fairness. A registered output slice drives the framebuffer write port.

---
 rtl/fb_write_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin arbiter that shares the framebuffer pixel-write
// port between drawing engines. A grant is held for a whole primitive, up to MAX_GRANT cycles.
// Ports: clk, rst (sync, active-high); req_valid/req_last/req_addr/req_data in and
// req_ready out, one lane per engine; fb_valid/fb_addr/fb_data/fb_src out and
// fb_ready in, toward the framebuffer; busy and burst_err (sticky) status out.
module fb_write_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int MAX_GRANT = 1024,
  localparam int SRC_W    = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(MAX_GRANT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fb_valid,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic [DATA_W-1:0]         fb_data,
  output logic [SRC_W-1:0]          fb_src,
  input  logic                      fb_ready,
  output logic                      busy,
  output logic                      burst_err
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_GRANT - 1);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

  state_t           state, state_n;
  logic [SRC_W-1:0] gnt, gnt_n;
  logic [SRC_W-1:0] rr_ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             err_n;
  logic             slot_free;
  logic             accept;
  logic             found;
  logic [SRC_W-1:0] pick;
  logic [SRC_W-1:0] gnt_inc;

  assign slot_free = !fb_valid || fb_ready;
  assign gnt_inc   = (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
  assign busy      = (state == GRANT) || fb_valid;

  // First valid engine at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        pick  = SRC_W'(j);
      end
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    ptr_n     = rr_ptr;
    cnt_n     = cnt;
    err_n     = burst_err;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n   = pick;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        req_ready[gnt] = slot_free;
        accept         = slot_free && req_valid[gnt];
        if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
        // A last beat on the watchdog cycle counts as a normal release.
        if (accept && req_last[gnt]) begin
          state_n = IDLE;
          ptr_n   = gnt_inc;
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE;
          ptr_n   = gnt_inc;
          err_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      burst_err <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      rr_ptr    <= ptr_n;
      cnt       <= cnt_n;
      burst_err <= err_n;
    end
  end

  // Output slice: loads on accept, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_valid <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      fb_src   <= '0;
    end else if (accept) begin
      fb_valid <= 1'b1;
      fb_addr  <= req_addr[gnt*ADDR_W +: ADDR_W];
      fb_data  <= req_data[gnt*DATA_W +: DATA_W];
      fb_src   <= gnt;
    end else if (fb_ready) begin
      fb_valid <= 1'b0;
    end
  end

endmodule
